vec_magnitude_iter: RTL and testbench
=====================================

Name: vec_magnitude_iter

Overview:
- Parametrised successor to the single-cycle approximate magnitude block; computes the exact integer magnitude floor(sqrt(x^2 + y^2)) of a WIDTH-bit unsigned vector (x, y).
- Optional round-to-nearest per transaction.
- Multi-cycle iterative square root (one result bit per cycle) behind valid/ready handshakes, so it sits between an input sampler and an output consumer without combinational sqrt logic.

Parameters:
- WIDTH, 8, bit width of each of x and y (supported range 2..16).

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  global enable; when low the block freezes (see Behaviour).
- in_valid  in  1  x, y and round are valid this cycle.
- in_ready  out  1  block can accept a transaction.
- x  in  WIDTH  unsigned x component.
- y  in  WIDTH  unsigned y component.
- round  in  1  0 = floor result, 1 = round-to-nearest result.
- out_valid  out  1  result fields are valid.
- out_ready  in  1  consumer accepts the result.
- mag  out  WIDTH+1  magnitude result.
- sumsq  out  2*WIDTH+1  x^2 + y^2 of the transaction.
- exact  out  1  1 when x^2 + y^2 is a perfect square.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset:
  - rst=1 at a rising edge forces state IDLE, out_valid=0, mag=0, sumsq=0, exact=0, busy=0, and clears the internal iteration counter.
  - Reset overrides ena and any in-flight transaction; a partially computed result is discarded and never presented.
- States: IDLE, SUM, ROOT, DONE.
- in_ready = ena && (state==IDLE). Acceptance occurs on a rising edge where in_valid && in_ready.
- IDLE:
  - On acceptance, register x, y and round, then go to SUM.
- SUM (1 cycle):
  - sumsq <= x*x + y*y, computed at full 2*WIDTH+1 bit width with no truncation.
  - Load the root engine: remainder=0, root=0, counter=WIDTH+1. Go to ROOT.
- ROOT (exactly WIDTH+1 cycles):
  - Restoring radix-2 square root over the radicand sumsq zero-extended to 2*WIDTH+2 bits. Each cycle consumes the next two MSBs and produces one root bit.
  - On the final iteration:
    - Floor root r and remainder rem = sumsq - r^2 are known.
    - exact <= (rem==0).
    - mag <= r + 1 if round && (rem > r), else r.
    - Go to DONE.
  - mag cannot overflow: the maximum rounded result, ceil(sqrt(2)*(2^WIDTH-1)), fits in WIDTH+1 bits.
- DONE:
  - out_valid=1; mag, sumsq and exact are held stable.
  - On an edge with out_ready=1, go to IDLE and drop out_valid.
  - out_valid stays high indefinitely under backpressure.
- Latency: out_valid rises WIDTH+2 enabled clock edges after the accepting edge (10 for WIDTH=8). Minimum turnaround between acceptances is WIDTH+4 edges.
- ena=0:
  - No state, counter or datapath register changes; in_ready=0.
  - out_valid and the result fields keep their values; a DONE handshake is not taken.
  - Latency extends by exactly the number of disabled cycles.
- Simultaneous events:
  - in_valid during a non-IDLE state is ignored; the upstream must hold it.
  - rst together with any handshake means reset wins.
- Outputs are registered; no combinational path from inputs to outputs other than in_ready depending on ena.
- Output fields are undefined-free: they retain the last completed result (or reset values) while out_valid=0.

Test Plan:
- Basic exact case, WIDTH=8: x=3, y=4, round=0 -> after 10 edges out_valid=1, mag=5, sumsq=25, exact=1; out_ready=1 returns to IDLE next edge, in_ready=1.
- Maximum input with rounding: x=255, y=255.
  - round=0 -> mag=360, sumsq=130050, exact=0.
  - Same inputs with round=1 -> mag=361 (rem=450 > 360).
- Boundary small values:
  - x=0, y=0 -> mag=0, exact=1.
  - x=1, y=1, round=1 -> mag=1 (rem=1 not > 1), sumsq=2, exact=0.
  - x=0, y=255 -> mag=255, exact=1.
- Backpressure: complete x=6, y=8, hold out_ready=0 for 5 cycles -> out_valid, mag=10 and sumsq=100 stable; in_ready=0 throughout; in_valid pulses with other data are ignored; release gives exactly one handshake.
- Enable stall: accept x=5, y=12, drop ena for 3 cycles during ROOT -> out_valid rises at edge 13 instead of 10; mag=13, exact=1.
- Reset mid-operation: assert rst for one cycle during ROOT -> next cycle state IDLE, out_valid=0, mag=0, sumsq=0, busy=0. A fresh transaction x=8, y=15 then gives mag=17 with normal latency.

Source files
------------

// File: rtl/vec_magnitude_iter_if.sv
// Handshake bundle for vec_magnitude_iter: input sampler side (x, y, round)
// and result consumer side (mag, sumsq, exact).
interface vec_magnitude_iter_if #(
    parameter int WIDTH = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   x;
    logic [WIDTH-1:0]   y;
    logic               round;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH:0]     mag;
    logic [2*WIDTH:0]   sumsq;
    logic               exact;

    modport master (
        output in_valid, x, y, round, out_ready,
        input  in_ready, out_valid, mag, sumsq, exact
    );

    modport slave (
        input  in_valid, x, y, round, out_ready,
        output in_ready, out_valid, mag, sumsq, exact
    );
endinterface

// File: rtl/vec_magnitude_iter.sv
// Exact integer magnitude floor(sqrt(x^2+y^2)) with optional rounding,
// computed by a restoring square root producing one root bit per cycle.
module vec_magnitude_iter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    vec_magnitude_iter_if.slave  bus,
    output logic                 busy
);
    localparam int N  = WIDTH + 1;
    localparam int SW = 2 * WIDTH + 1;
    localparam int DW = 2 * WIDTH + 2;
    localparam int RW = WIDTH + 4;
    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUM  = 2'd1,
        ROOT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] x_q, y_q;
    logic             round_q;
    logic [DW-1:0]    rad;
    logic [RW-1:0]    rem;
    logic [N-1:0]     root;
    logic [CW-1:0]    cnt;
    logic [N-1:0]     mag_q;
    logic [SW-1:0]    sumsq_q;
    logic             exact_q;

    logic [SW-1:0]    sq;
    logic [RW-1:0]    rem_sh, trial, rem_nx;
    logic [N-1:0]     root_nx;
    logic             last;

    assign bus.in_ready  = ena && (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.mag       = mag_q;
    assign bus.sumsq     = sumsq_q;
    assign bus.exact     = exact_q;
    assign busy          = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (ena) begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        last     = (cnt == CW'(1));
        unique case (state)
            IDLE: if (bus.in_valid) state_nx = SUM;
            SUM:  state_nx = ROOT;
            ROOT: if (last) state_nx = DONE;
            DONE: if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // One restoring step: bring down two radicand bits, try subtracting 4r+1.
    always_comb begin
        sq      = SW'(x_q) * SW'(x_q) + SW'(y_q) * SW'(y_q);
        rem_sh  = (rem << 2) | RW'(rad[DW-1:DW-2]);
        trial   = RW'({root, 2'b01});
        rem_nx  = rem_sh;
        root_nx = root << 1;
        if (rem_sh >= trial) begin
            rem_nx  = rem_sh - trial;
            root_nx = (root << 1) | N'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            round_q <= 1'b0;
            rad     <= '0;
            rem     <= '0;
            root    <= '0;
            cnt     <= '0;
            mag_q   <= '0;
            sumsq_q <= '0;
            exact_q <= 1'b0;
        end else if (ena) begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        x_q     <= bus.x;
                        y_q     <= bus.y;
                        round_q <= bus.round;
                    end
                end
                SUM: begin
                    sumsq_q <= sq;
                    rad     <= {1'b0, sq};
                    rem     <= '0;
                    root    <= '0;
                    cnt     <= CW'(N);
                end
                ROOT: begin
                    rad  <= rad << 2;
                    rem  <= rem_nx;
                    root <= root_nx;
                    cnt  <= cnt - CW'(1);
                    if (last) begin
                        exact_q <= (rem_nx == '0);
                        // Remainder exceeding r means sqrt lies above r + 0.5.
                        mag_q   <= (round_q && (rem_nx > RW'(root_nx)))
                                   ? root_nx + N'(1) : root_nx;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_vec_magnitude_iter.sv
// Directed scoreboard bench for vec_magnitude_iter (WIDTH=8).
module tb_vec_magnitude_iter;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ena = 1'b1;
    logic busy;

    vec_magnitude_iter_if #(.WIDTH(WIDTH)) bus ();

    vec_magnitude_iter #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .ena  (ena),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mag;
        int sumsq;
        int exact;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;
    bit   done   = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: compare every result handshake against the scoreboard head.
    always @(negedge clk) begin
        if (!done && !rst && ena && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("mag",   int'(bus.mag),   e.mag);
                chk("sumsq", int'(bus.sumsq), e.sumsq);
                chk("exact", int'(bus.exact), e.exact);
            end
        end
    end

    task automatic send(input int xv, input int yv, input bit rv,
                        input int em, input int es, input bit ee, input bit push);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("in_ready_timeout", 0, 1);
        bus.x        = WIDTH'(xv);
        bus.y        = WIDTH'(yv);
        bus.round    = rv;
        bus.in_valid = 1'b1;
        if (push) sb.push_back('{em, es, int'(ee)});
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int start, input int req, input string name);
        int n;
        n = start;
        while (!bus.out_valid && n < 60) begin
            @(posedge clk);
            n++;
            #1;
        end
        chk(name, n, req);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (bus.out_valid && n < 60) begin
            @(posedge clk);
            n++;
            #1;
        end
        chk("drain_in_ready", int'(bus.in_ready), 1);
    endtask

    task automatic run(input int xv, input int yv, input bit rv,
                       input int em, input int es, input bit ee);
        send(xv, yv, rv, em, es, ee, 1'b1);
        wait_valid(0, WIDTH + 2, "latency");
        drain();
    endtask

    initial begin
        int n;
        bus.in_valid  = 1'b0;
        bus.x         = '0;
        bus.y         = '0;
        bus.round     = 1'b0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_mag",       int'(bus.mag),       0);
        chk("rst_sumsq",     int'(bus.sumsq),     0);
        chk("rst_exact",     int'(bus.exact),     0);
        chk("rst_busy",      int'(busy),          0);
        chk("rst_in_ready",  int'(bus.in_ready),  1);

        run(3, 4, 1'b0, 5, 25, 1'b1);
        run(255, 255, 1'b0, 360, 130050, 1'b0);
        run(255, 255, 1'b1, 361, 130050, 1'b0);
        run(0, 0, 1'b0, 0, 0, 1'b1);
        run(1, 1, 1'b1, 1, 2, 1'b0);
        run(0, 255, 1'b0, 255, 65025, 1'b1);
        run(7, 7, 1'b1, 10, 98, 1'b0);

        // Backpressure with ignored in_valid pulses carrying other data.
        bus.out_ready = 1'b0;
        send(6, 8, 1'b0, 10, 100, 1'b1, 1'b1);
        wait_valid(0, WIDTH + 2, "bp_latency");
        for (int i = 0; i < 5; i++) begin
            bus.x        = 8'd1;
            bus.y        = 8'd2;
            bus.in_valid = 1'b1;
            @(negedge clk);
            chk("bp_out_valid", int'(bus.out_valid), 1);
            chk("bp_mag",       int'(bus.mag),       10);
            chk("bp_sumsq",     int'(bus.sumsq),     100);
            chk("bp_in_ready",  int'(bus.in_ready),  0);
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_released", int'(bus.out_valid), 0);
        chk("bp_sb_empty", sb.size(), 0);
        n = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.out_valid || busy) n++;
        end
        chk("bp_no_extra_txn", n, 0);

        // Enable stall of three cycles while in ROOT.
        send(5, 12, 1'b0, 13, 169, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1 ena = 1'b0;
        repeat (3) @(posedge clk);
        #1 ena = 1'b1;
        chk("stall_no_valid", int'(bus.out_valid), 0);
        wait_valid(6, WIDTH + 5, "stall_latency");
        drain();

        // Reset during ROOT discards the in-flight result.
        send(9, 9, 1'b0, 0, 0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", int'(bus.out_valid), 0);
        chk("mid_rst_mag",       int'(bus.mag),       0);
        chk("mid_rst_sumsq",     int'(bus.sumsq),     0);
        chk("mid_rst_busy",      int'(busy),          0);
        chk("mid_rst_in_ready",  int'(bus.in_ready),  1);
        run(8, 15, 1'b0, 17, 289, 1'b1);

        repeat (3) @(negedge clk);
        chk("final_sb_empty", sb.size(), 0);
        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
